// File: rtl/mul_share_ctrl_if.sv
`default_nettype none
// =============================================================================
// Module   : mul_share_ctrl_if
// Purpose  : Requester bus plus shared-multiplier datapath bus for mul_share_ctrl.
// Revision : 1.0 - initial release
// =============================================================================
interface mul_share_ctrl_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) ();
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       grant;
    logic                  done;
    logic [WIDTH-1:0]      result;
    logic                  busy;
    logic [WIDTH-1:0]      dp_data;
    logic                  ldA;
    logic                  ldB;
    logic                  ldP;
    logic                  clrP;
    logic                  decB;
    logic                  eqz;
    logic [WIDTH-1:0]      dp_prod;

    // The controller side.
    modport slave (
        input  req, a_in, b_in, eqz, dp_prod,
        output grant, done, result, busy, dp_data, ldA, ldB, ldP, clrP, decB
    );

    // The requesters plus datapath side.
    modport master (
        output req, a_in, b_in, eqz, dp_prod,
        input  grant, done, result, busy, dp_data, ldA, ldB, ldP, clrP, decB
    );
endinterface
`default_nettype wire

// File: rtl/mul_share_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : mul_share_ctrl
// Purpose  : Round-robin arbiter/sequencer sharing one repeated-addition
//            multiplier datapath among NREQ requesters. Optional operand swap
//            (smaller operand iterated) enabled by define MUL_SHARE_SWAP_EN.
// Revision : 1.0 - initial release
// =============================================================================
module mul_share_ctrl #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mul_share_ctrl_if.slave  bus
);
    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_RUN    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [IDXW-1:0]   r_win;
    logic [IDXW-1:0]   r_last;
    logic [IDXW-1:0]   w_pick;
    logic              w_found;
    int                w_idx;
    logic              r_swap;
    logic              w_swap;
    logic [WIDTH-1:0]  r_result;
    logic [WIDTH-1:0]  w_a_win;
    logic [WIDTH-1:0]  w_b_win;
    logic [WIDTH-1:0]  w_dp_data;
    logic              w_ldA;
    logic              w_ldB;
    logic              w_ldP;
    logic              w_clrP;
    logic              w_decB;

    // Round-robin search starting one past the last winner, wrapping modulo NREQ.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last;
        w_idx   = 0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = (int'(r_last) + k) % NREQ;
            if (!w_found && bus.req[w_idx[IDXW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[IDXW-1:0];
            end
        end
    end

`ifdef MUL_SHARE_SWAP_EN
    logic [WIDTH-1:0] w_a_pick;
    logic [WIDTH-1:0] w_b_pick;
    assign w_a_pick = bus.a_in[w_pick*WIDTH +: WIDTH];
    assign w_b_pick = bus.b_in[w_pick*WIDTH +: WIDTH];
    // Iterating on the smaller operand shortens RUN; the product is commutative.
    assign w_swap   = (w_b_pick > w_a_pick);
`else
    assign w_swap   = 1'b0;
`endif

    assign w_a_win = bus.a_in[r_win*WIDTH +: WIDTH];
    assign w_b_win = bus.b_in[r_win*WIDTH +: WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win    <= '0;
            r_last   <= IDXW'(NREQ - 1);
            r_swap   <= 1'b0;
            r_result <= '0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_win  <= w_pick;
                r_last <= w_pick;
                r_swap <= w_swap;
            end
            if (r_state == S_RUN && bus.eqz) begin
                r_result <= bus.dp_prod;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        w_dp_data = '0;
        w_ldA     = 1'b0;
        w_ldB     = 1'b0;
        w_ldP     = 1'b0;
        w_clrP    = 1'b0;
        w_decB    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                w_dp_data = r_swap ? w_b_win : w_a_win;
                w_ldA     = 1'b1;
                w_next    = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_dp_data = r_swap ? w_a_win : w_b_win;
                w_ldB     = 1'b1;
                w_clrP    = 1'b1;
                w_next    = S_RUN;
            end
            S_RUN: begin
                if (bus.eqz) begin
                    w_next = S_DONE;
                end else begin
                    w_ldP  = 1'b1;
                    w_decB = 1'b1;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs decode straight from state so asynchronous reset clears them at once.
    assign bus.grant   = (r_state != S_IDLE) ? (NREQ'(1) << r_win) : '0;
    assign bus.done    = (r_state == S_DONE);
    assign bus.busy    = (r_state != S_IDLE);
    assign bus.result  = r_result;
    assign bus.dp_data = w_dp_data;
    assign bus.ldA     = w_ldA;
    assign bus.ldB     = w_ldB;
    assign bus.ldP     = w_ldP;
    assign bus.clrP    = w_clrP;
    assign bus.decB    = w_decB;
endmodule
`default_nettype wire
